// File: rtl/trigger_led_pkg.sv
// Shared encodings for the trigger LED bank: per-channel mode and FSM state.
package trigger_led_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RETRIG  = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_LATCH   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/trigger_led_bank_if.sv
// Event/LED bundle between sniffer event sources and the LED bank.
//   trigger : async event inputs, one per channel
//   mode    : per-channel mode, bits [2i+1:2i] belong to channel i
//   clear   : synchronous per-channel clear
//   led     : LED drive, active-high
//   busy    : channel is ACTIVE
interface trigger_led_bank_if
  import trigger_led_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH-1:0]        trigger;
  logic [MODE_W*NUM_CH-1:0] mode;
  logic [NUM_CH-1:0]        clear;
  logic [NUM_CH-1:0]        led;
  logic [NUM_CH-1:0]        busy;

  modport master (output trigger, output mode, output clear, input led, input busy);
  modport slave  (input trigger, input mode, input clear, output led, output busy);
endinterface

// File: rtl/trigger_led_channel.sv
// One LED pulse-stretcher channel: trigger synchroniser, rising-edge detect,
// IDLE/ACTIVE FSM with hold and blink-phase counters.
//   clk, reset : clock, async active-high reset
//   trigger    : asynchronous event input
//   mode       : mode sampled on IDLE->ACTIVE
//   clear      : synchronous clear, wins over a same-cycle event
//   led, busy  : registered LED drive and ACTIVE flag
module trigger_led_channel
  import trigger_led_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1_000_000,
  parameter int unsigned BLINK_HALF  = 250_000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger,
  input  logic [MODE_W-1:0] mode,
  input  logic              clear,
  output logic              led,
  output logic              busy
);

  localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHASE_RELOAD = CNT_W'(BLINK_HALF - 1);

  if (HOLD_CYCLES < 1 || BLINK_HALF < 1) begin : g_bad_time
    $error("trigger_led_channel: HOLD_CYCLES and BLINK_HALF must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("trigger_led_channel: SYNC_STAGES must be >= 2");
  end
  if (CNT_W < 1 || CNT_W > 63 ||
      (64'd1 << CNT_W) <= 64'(HOLD_CYCLES) ||
      (64'd1 << CNT_W) <= 64'(BLINK_HALF)) begin : g_bad_cnt_w
    $error("trigger_led_channel: CNT_W too small for HOLD_CYCLES/BLINK_HALF");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   hist_q;
  logic                   event_q;
  logic                   trig_s;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             led_q, led_d;

  assign trig_s = sync_q[SYNC_STAGES-1];

  // Synchroniser and registered edge detect. fill_q marks when the chain
  // holds real input samples again after reset; until then the edge history
  // is pinned high so a trigger held through reset release raises no event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b1;
      event_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], trigger};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      hist_q  <= fill_q[SYNC_STAGES-1] ? trig_s : 1'b1;
      event_q <= trig_s & ~hist_q;
    end
  end

  // Next state, counters and LED.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    phase_d = phase_q;
    led_d   = led_q;
    if (clear) begin
      state_d = ST_IDLE;
      led_d   = 1'b0;
      hold_d  = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          led_d   = 1'b0;
          hold_d  = '0;
          phase_d = '0;
          if (event_q) begin
            state_d = ST_ACTIVE;
            mode_d  = mode_e'(mode);
            hold_d  = HOLD_RELOAD;
            phase_d = PHASE_RELOAD;
            led_d   = 1'b1;
          end
        end
        ST_ACTIVE: begin
          case (mode_q)
            MODE_LATCH: led_d = 1'b1;
            MODE_ONESHOT: begin
              // Events are ignored; an event coinciding with expiry is consumed.
              if (hold_q == '0) begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
                phase_d = '0;
              end else begin
                hold_d = hold_q - CNT_W'(1);
              end
            end
            default: begin
              // RETRIG and BLINK: a reload beats a same-cycle expiry.
              if (event_q) begin
                hold_d = HOLD_RELOAD;
              end else if (hold_q == '0) begin
                state_d = ST_IDLE;
                led_d   = 1'b0;
                phase_d = '0;
              end else begin
                hold_d = hold_q - CNT_W'(1);
              end
              // Blink phase runs free across retriggers.
              if (mode_q == MODE_BLINK && state_d == ST_ACTIVE) begin
                if (phase_q == '0) begin
                  led_d   = ~led_q;
                  phase_d = PHASE_RELOAD;
                end else begin
                  phase_d = phase_q - CNT_W'(1);
                end
              end
            end
          endcase
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONESHOT;
      hold_q  <= '0;
      phase_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led  = led_q;
  assign busy = (state_q == ST_ACTIVE);

endmodule

// File: rtl/trigger_led_bank.sv
// Multi-channel LED pulse stretcher for sniffer status events.
//   clk, reset : clock, async active-high reset
//   bus        : trigger/mode/clear in, led/busy out (NUM_CH wide)
module trigger_led_bank
  import trigger_led_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned HOLD_CYCLES = 1_000_000,
  parameter int unsigned BLINK_HALF  = 250_000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 24
) (
  input logic               clk,
  input logic               reset,
  trigger_led_bank_if.slave bus
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("trigger_led_bank: NUM_CH must be 1..8");
  end

  logic [NUM_CH-1:0] led_w;
  logic [NUM_CH-1:0] busy_w;

  // One independent channel per trigger; mode bus sliced per channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trigger_led_channel #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .BLINK_HALF  (BLINK_HALF),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .trigger (bus.trigger[i]),
      .mode    (bus.mode[MODE_W*i +: MODE_W]),
      .clear   (bus.clear[i]),
      .led     (led_w[i]),
      .busy    (busy_w[i])
    );
  end

  assign bus.led  = led_w;
  assign bus.busy = busy_w;

endmodule

// File: tb/tb_trigger_led_bank.sv
// Directed bench for trigger_led_bank: NUM_CH=2, HOLD=10, BLINK_HALF=3, SYNC=2.
// Cycle c of run(): inputs set before posedge c, outputs sampled 1 ns after it;
// an event sampled at edge c shows on led after edge c+3.
module tb_trigger_led_bank;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned HOLD   = 10;
  localparam int unsigned BLINK  = 3;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned CNT_W  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trigger_led_bank_if #(.NUM_CH(NUM_CH)) bus ();

  trigger_led_bank #(
    .NUM_CH      (NUM_CH),
    .HOLD_CYCLES (HOLD),
    .BLINK_HALF  (BLINK),
    .SYNC_STAGES (SYNC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int highs;
  logic [63:0] l0, l1, b0, b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse tmask channels at cycles p1/p2, clear them at pc, set mode to mv at mc;
  // record led/busy history of both channels.
  task automatic run(input logic [1:0] tmask, input int p1, input int p2, input int pc,
                     input int mc, input logic [3:0] mv, input int n);
    l0 = '0; l1 = '0; b0 = '0; b1 = '0;
    for (int c = 0; c < n; c++) begin
      bus.trigger = (c == p1 || c == p2) ? tmask : 2'b00;
      bus.clear   = (c == pc) ? tmask : 2'b00;
      if (c == mc) bus.mode = mv;
      tick();
      l0[c] = bus.led[0];
      l1[c] = bus.led[1];
      b0[c] = bus.busy[0];
      b1[c] = bus.busy[1];
    end
    bus.trigger = '0;
    bus.clear   = '0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.trigger = '0;
    bus.clear   = '0;
    bus.mode    = '0;
    repeat (2) tick();
    check("reset_led", 64'(bus.led), 64'h0);
    check("reset_busy", 64'(bus.busy), 64'h0);
    reset = 1'b0;
    repeat (4) tick();

    // 1. ONESHOT on ch0, second pulse 4 cycles later ignored: led high edges 3..12
    bus.mode = 4'b0000;
    run(2'b01, 0, 4, -1, -1, 4'b0000, 20);
    check("oneshot_led", l0, 64'h1FF8);
    check("oneshot_busy", b0, 64'h1FF8);

    // 2. RETRIG on ch1, pulses at 0 and 6: reload at edge 9, high edges 3..18
    bus.mode = 4'b0100;
    run(2'b10, 0, 6, -1, -1, 4'b0000, 30);
    check("retrig_led", l1, 64'h7FFF8);
    check("retrig_busy", b1, 64'h7FFF8);
    check("retrig_ch0_quiet", l0, 64'h0);

    // 3. BLINK on ch0: 1,1,1,0,0,0,1,1,1,0 from edge 3
    bus.mode = 4'b0010;
    run(2'b01, 0, -1, -1, -1, 4'b0000, 20);
    check("blink_led", l0, 64'hE38);
    check("blink_busy", b0, 64'h1FF8);

    // 4. LATCH on ch0, then clear coinciding with a new event
    bus.mode = 4'b0011;
    run(2'b01, 0, -1, -1, -1, 4'b0000, 20);
    check("latch_led", l0, 64'hFFFF8);
    highs = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.led[0]) highs++;
    end
    check("latch_1000", 64'(highs), 64'd1000);
    run(2'b01, 0, -1, 3, -1, 4'b0000, 20);
    check("clear_led", l0, 64'h7);
    check("clear_busy", b0, 64'h7);

    // 5. Async reset while ACTIVE, trigger held high through release
    bus.mode       = 4'b0000;
    bus.trigger[0] = 1'b1;
    repeat (5) tick();
    check("rst_pre_led", 64'(bus.led[0]), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_led", 64'(bus.led), 64'h0);
    check("rst_async_busy", 64'(bus.busy), 64'h0);
    tick();
    reset = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.led[0] || bus.busy[0]) highs++;
    end
    check("rst_held_no_event", 64'(highs), 64'd0);
    bus.trigger = '0;
    repeat (3) tick();
    run(2'b01, 0, -1, -1, -1, 4'b0000, 20);
    check("rst_rearm_led", l0, 64'h1FF8);

    // 6. ch0 ONESHOT + ch1 BLINK together, ch0 mode -> LATCH mid-hold
    bus.mode = 4'b1000;
    run(2'b11, 0, -1, -1, 6, 4'b1011, 20);
    check("indep_ch0_led", l0, 64'h1FF8);
    check("indep_ch0_busy", b0, 64'h1FF8);
    check("indep_ch1_led", l1, 64'hE38);
    check("indep_ch1_busy", b1, 64'h1FF8);

    repeat (3) tick();
    check("final_idle", 64'({bus.led, bus.busy}), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/trigger_led_bank.md
Name: trigger_led_bank

Overview:
Multi-channel, parametrised LED pulse stretcher for sniffer status indication (frame hit, TPM match, FIFO overflow and similar events).
Each channel synchronises an asynchronous trigger, detects its rising edge, and drives an LED for a programmable time in one of four modes.
Sits between the sniffer event sources and the iCEstick LED pins.
It supersedes the single-channel, fixed-time, non-synchronised LED trigger.

Parameters:
NUM_CH, 4, number of independent channels (1..8)
HOLD_CYCLES, 1_000_000, LED on-time in clk cycles (>=1)
BLINK_HALF, 250_000, blink half-period in clk cycles (>=1)
SYNC_STAGES, 2, trigger synchroniser depth (>=2)
CNT_W, 24, hold/phase counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, BLINK_HALF)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
trigger  in  NUM_CH  asynchronous event inputs, one per channel
mode  in  2*NUM_CH  per-channel mode; bits [2i+1:2i] belong to channel i
clear  in  NUM_CH  synchronous per-channel clear
led  out  NUM_CH  LED drive, active-high
busy  out  NUM_CH  channel is in its ACTIVE state

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting it forces led=0, busy=0, all counters=0 and synchroniser stages=0. The edge-history register resets to 1, so a trigger held high through reset release raises no event; the input must be seen low first.
- Event definition: event_i = synchronised trigger_i high AND previous synchronised sample low.
- Latency: trigger_i first sampled high at posedge k gives led_i=1 after posedge k+SYNC_STAGES+1 (3 cycles at default).
- Per-channel FSM states: IDLE, ACTIVE.
- IDLE -> ACTIVE on event_i. At that edge: latch mode_i into mode_q; load hold_cnt=HOLD_CYCLES-1 and phase_cnt=BLINK_HALF-1; set led=1.
- Mode 0 ONESHOT: events in ACTIVE are ignored. hold_cnt decrements each cycle. When hold_cnt==0, go to IDLE and set led=0. The LED is high for exactly HOLD_CYCLES cycles.
- Mode 1 RETRIG: as ONESHOT, except an event in ACTIVE reloads hold_cnt=HOLD_CYCLES-1. The LED stays high HOLD_CYCLES cycles after the last event.
- Mode 2 BLINK: retrigger rules as RETRIG. phase_cnt decrements each cycle. When phase_cnt==0, toggle led and reload BLINK_HALF-1. A retrigger does not reset phase. On exit to IDLE, led=0 regardless of phase.
- Mode 3 LATCH: hold_cnt is unused. The channel stays ACTIVE with led=1 until clear_i.
- Mode changes while ACTIVE have no effect until the next IDLE->ACTIVE transition, because mode_q is latched at entry.
- clear_i in any state or mode: next state IDLE, led=0, counters=0.
- clear_i has priority over a same-cycle event; that event is dropped.
- Expiry (hold_cnt==0) in the same cycle as an event:
  - RETRIG and BLINK: the reload wins; stay ACTIVE.
  - ONESHOT: go to IDLE. The event is consumed and does not restart the channel.
- busy_i = (state==ACTIVE). Both led and busy are registered, with no combinational path from the inputs.
- Channels are fully independent; simultaneous events on all channels are all honoured.
- Counter arithmetic is unsigned CNT_W-bit. Counters never decrement below 0 (no wrap-around); they are only reloaded or held at 0 in IDLE.
- Elaboration check: assert HOLD_CYCLES>=1, BLINK_HALF>=1 and the CNT_W range condition.

Decomposition:
- Shared package trigger_led_pkg holds the mode encodings (MODE_ONESHOT=2'd0, MODE_RETRIG=2'd1, MODE_BLINK=2'd2, MODE_LATCH=2'd3) and the FSM state encodings (ST_IDLE, ST_ACTIVE).
- Sub-module trigger_led_channel implements one channel: synchroniser, edge detect, FSM and counters.
- trigger_led_bank is a generate loop of NUM_CH instances plus the mode bus slicing.

Test Plan:
All scenarios use NUM_CH=2, HOLD_CYCLES=10, BLINK_HALF=3, SYNC_STAGES=2.
1. ONESHOT: 1-cycle trigger pulse on ch0 -> led[0] rises 3 cycles after sampling and stays high exactly 10 cycles. A second pulse 4 cycles later is ignored, so the total high time is still 10.
2. RETRIG: pulses on ch1 at cycles 0 and 6 -> led[1] stays high continuously until 10 cycles after the second event's entry (16 cycles high total). busy[1] tracks led[1].
3. BLINK: single pulse on ch0 -> led[0] pattern is 1,1,1,0,0,0,1,1,1,0 over 10 cycles, then 0 with busy[0]=0.
4. LATCH plus clear: pulse on ch0 -> led[0] stays 1 for 1000 cycles. clear[0] asserted in the same cycle as a new event -> led[0]=0 next cycle and no restart.
5. Reset and edge guard: assert reset while ch0 is ACTIVE with trigger held high -> led=0 and busy=0 immediately (asynchronously). After reset release with trigger still high, no event occurs. A low-then-high trigger then raises a normal event.
6. Independence and mode latch: simultaneous pulses on ch0 (ONESHOT) and ch1 (BLINK), then mode[1:0] changed to LATCH mid-hold -> both channels behave per their entry modes and ch0 expires after 10 cycles.
